// File: rtl/tt_um_s_grundner.sv
// tt_um_s_grundner: 8-bit loadable up/down counter with compare register, PWM, TC and heartbeat.
// Optional count prescaler is compiled in with TT_PRESCALE_EN.
module tt_um_s_grundner #(
  parameter int PRESCALE_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [7:0] count, cmp, nxt;
  logic       tc, hb, tick, step, wrap, load, up, cnt_en, cmp_wr, unused;
  assign load   = uio_in[0];
  assign up     = uio_in[1];
  assign cnt_en = uio_in[2];
  assign cmp_wr = uio_in[3];
  assign unused = &{1'b0, uio_in[7:4], PRESCALE_LOG2 == 0};
`ifdef TT_PRESCALE_EN
  logic [PRESCALE_LOG2-1:0] pre;
  always_ff @(posedge clk)
    if (!rst_n) pre <= '0;
    else if (ena) pre <= pre + 1'b1;
  assign tick = &pre;
`else
  assign tick = 1'b1;
`endif
  assign step = !load && cnt_en && tick;
  assign nxt  = up ? count + 8'd1 : count - 8'd1;
  // a wrap is a step leaving 0xFF upward or 0x00 downward; loads never count
  assign wrap = step && (count == (up ? 8'hFF : 8'h00));
  always_ff @(posedge clk)
    if (!rst_n) begin
      count <= 8'h00;
      cmp   <= 8'h80;
      tc    <= 1'b0;
      hb    <= 1'b0;
    end else if (ena) begin
      count <= load ? ui_in : step ? nxt : count;
      if (cmp_wr) cmp <= ui_in;
      tc    <= wrap;
      hb    <= hb ^ wrap;
    end
  assign uo_out  = count;
  assign uio_out = {hb, count == cmp, tc, count < cmp, 4'h0};
  assign uio_oe  = 8'hF0;
endmodule

// File: tb/tb_tt_um_s_grundner.sv
// tb_tt_um_s_grundner: directed self-checking bench for the counter tile (prescaler compiled out).
module tb_tt_um_s_grundner;
  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
  int checks = 0, failures = 0;

  tt_um_s_grundner dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic both(input string tag, input logic [7:0] ec, input logic [7:0] es);
    chk({tag, "_cnt"}, uo_out, ec);
    chk({tag, "_st"}, uio_out, es);
  endtask

  initial begin
    logic [7:0] ecnt [4];
    logic [7:0] est [4];
    rst_n = 1'b0; ena = 1'b1;
    ui_in = 8'($urandom); uio_in = 8'($urandom);
    cyc;
    ui_in = 8'($urandom); uio_in = 8'($urandom);
    cyc;
    both("reset", 8'h00, 8'h10);
    chk("oe", uio_oe, 8'hF0);
    rst_n = 1'b1;
    // load then count up across the 0xFF -> 0x00 wrap
    uio_in = 8'h01; ui_in = 8'hFE; cyc; both("ld_fe", 8'hFE, 8'h00);
    uio_in = 8'h06; cyc; both("up_ff", 8'hFF, 8'h00);
    cyc; both("up_wrap", 8'h00, 8'hB0);
    cyc; both("up_01", 8'h01, 8'h90);
    // down wrap
    uio_in = 8'h01; ui_in = 8'h01; cyc; both("ld_01", 8'h01, 8'h90);
    uio_in = 8'h04; cyc; both("dn_00", 8'h00, 8'h90);
    cyc; both("dn_wrap", 8'hFF, 8'h20);
    cyc; both("dn_fe", 8'hFE, 8'h00);
    // compare write, then count through the threshold
    uio_in = 8'h08; ui_in = 8'h03; cyc; both("cmp_wr", 8'hFE, 8'h00);
    uio_in = 8'h01; ui_in = 8'h00; cyc; both("ld_00", 8'h00, 8'h10);
    ecnt = '{8'h01, 8'h02, 8'h03, 8'h04};
    est  = '{8'h10, 8'h10, 8'h40, 8'h00};
    uio_in = 8'hF6;
    for (int i = 0; i < 4; i++) begin
      cyc; both($sformatf("pwm%0d", i), ecnt[i], est[i]);
    end
    // load and compare write share ui_in in one cycle
    uio_in = 8'h09; ui_in = 8'h20; cyc; both("ld_cmp", 8'h20, 8'h40);
    // enable gating: every strobe ignored, state held
    ena = 1'b0; uio_in = 8'h0F; ui_in = 8'h55;
    for (int i = 0; i < 5; i++) begin
      cyc; both($sformatf("gate%0d", i), 8'h20, 8'h40);
    end
    ena = 1'b1; uio_in = 8'h06; ui_in = 8'h00; cyc; both("resume", 8'h21, 8'h00);
    // load beats count enable
    uio_in = 8'h05; ui_in = 8'h10; cyc; both("prio", 8'h10, 8'h10);
    uio_in = 8'h04; cyc; both("prio_dn", 8'h0F, 8'h10);
    // load to 0xFF gives no TC; next up step wraps; TC holds while disabled
    uio_in = 8'h01; ui_in = 8'hFF; cyc; both("ld_ff", 8'hFF, 8'h00);
    uio_in = 8'h06; cyc; both("wrap2", 8'h00, 8'hB0);
    ena = 1'b0; cyc; both("tc_hold", 8'h00, 8'hB0);
    ena = 1'b1; uio_in = 8'h00; cyc; both("tc_clr", 8'h00, 8'h90);
    // reset overrides enabled strobes
    rst_n = 1'b0; uio_in = 8'h0F; ui_in = 8'h77; cyc; both("rst2", 8'h00, 8'h10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
